uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
Sits directly downstream of the UART receiver. Consumes its one-cycle byte-valid strobe and byte, and hunts for a sync byte. Assembles a fixed 7-byte plotter command frame and checks an XOR checksum. Presents each good command to the motion controller over a valid/ready handshake, and reports framing errors as one-cycle pulses.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CLKS, 17360, max clocks between bytes inside a frame (4 byte-times at 434 clks/bit).

Ports:
i_Clock  in  1  system clock, all logic on rising edge.
i_Reset_n  in  1  asynchronous, active-low reset.
i_RX_DV  in  1  byte-valid strobe from UART receiver, one cycle wide.
i_RX_Byte  in  8  received byte, sampled only when i_RX_DV=1.
o_Cmd_Valid  out  1  command held in output register.
i_Cmd_Ready  in  1  consumer accepts; transfer when o_Cmd_Valid && i_Cmd_Ready.
o_Cmd_Op  out  8  opcode (not decoded here).
o_Cmd_X  out  16  X coordinate, big-endian in frame.
o_Cmd_Y  out  16  Y coordinate, big-endian in frame.
o_Chk_Err  out  1  one-cycle pulse: checksum mismatch.
o_Timeout_Err  out  1  one-cycle pulse: inter-byte timeout.
o_Overrun_Err  out  1  one-cycle pulse: good frame dropped, output register busy.
o_Busy  out  1  parser is mid-frame (state != HUNT).

Behaviour:
- Frame: SYNC, OP, XH, XL, YH, YL, CHK. CHK = OP^XH^XL^YH^YL. SYNC is not included in CHK.
- Reset (async assert, sync-safe deassert): state=HUNT, timeout counter=0, all outputs 0, payload registers 0.
- States: HUNT, OP, XH, XL, YH, YL, CHK. Each advances only on i_RX_DV.
- HUNT: a byte == SYNC_BYTE goes to OP. Any other byte is ignored and the state stays HUNT.
- OP..YL: the byte is stored in the shadow register and the state advances. A SYNC_BYTE value here is treated as data, with no resync.
- CHK: the state always returns to HUNT. On mismatch, o_Chk_Err pulses in the next cycle and the frame is discarded.
- On match, with the output free (!o_Cmd_Valid, or i_Cmd_Ready in this same cycle):
  - the shadow registers are copied to the outputs;
  - o_Cmd_Valid=1 in the next cycle.
  - Latency: o_Cmd_Valid is high 1 clock after the CHK byte's i_RX_DV.
- On match with the output busy (o_Cmd_Valid && !i_Cmd_Ready): the frame is dropped and o_Overrun_Err pulses. The outputs keep the older command.
- Output hold: o_Cmd_Op/X/Y are stable while o_Cmd_Valid=1. o_Cmd_Valid clears the cycle after the transfer, unless a new command loads in that same cycle.
- Timeout: the counter runs only when state != HUNT and i_RX_DV=0, and clears on any i_RX_DV.
  - When the counter reaches TIMEOUT_CLKS-1: go to HUNT, pulse o_Timeout_Err, clear the counter.
  - If i_RX_DV arrives in that same cycle, the byte wins and no timeout occurs.
  - Counter width is $clog2(TIMEOUT_CLKS+1).
- o_Busy = (state != HUNT), registered.
- Error pulses never overlap each other for the same frame.

Optional Feature:
UART_CMD_ECHO_EN
- Defined: adds outputs o_Echo_DV (1) and o_Echo_Byte (8) for a UART transmitter. One cycle after frame end, o_Echo_DV pulses with:
  - 8'h06 (ACK) for a good, accepted frame;
  - 8'h15 (NAK) for a checksum error, overrun or timeout.
  - Reset value 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state enum (HUNT..CHK);
  - ACK/NAK byte constants;
  - frame length (7);
  - plotter opcode constants (OP_MOVE 8'h01, OP_PEN_UP 8'h02, OP_PEN_DOWN 8'h03, OP_HOME 8'h04), for consumers.
- One sub-module, uart_cmd_timeout: the clear/enable/expire counter parameterised by TIMEOUT_CLKS.

Test Plan:
- Good frame: i_Cmd_Ready=1, send A5 01 01 F4 00 C8 3C. Expect o_Cmd_Valid 1 clk after the last DV, Op=01, X=0x01F4, Y=0x00C8, no error pulses.
- Bad checksum: send A5 01 01 F4 00 C8 3D. Expect an o_Chk_Err pulse and no o_Cmd_Valid; the following good frame is accepted.
- Noise/hunt: send 00 FF 5A, then the good frame. Expect exactly one command, X=0x01F4.
- Timeout: send A5 01, then idle TIMEOUT_CLKS clocks. Expect an o_Timeout_Err pulse and o_Busy=0; a subsequent good frame is accepted.
- Overrun: i_Cmd_Ready=0, send the good frame, then A5 02 00 00 00 00 02. Expect an o_Overrun_Err pulse and outputs still Op=01. Raise ready: one transfer, o_Cmd_Valid drops.
- Reset mid-frame: assert i_Reset_n=0 after A5 01 01, then release and send the good frame. Expect all outputs 0 during reset, then one correct command; with UART_CMD_ECHO_EN, o_Echo_Byte=06.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
//
// Purpose:
//    Shared definitions for the UART plotter command parser: the frame
//    parsing states, the echo acknowledge bytes, the frame length, the
//    plotter opcode values used by downstream consumers, and the frame
//    checksum helper.
//
// Ports:
//    none (package)
//
// Optional build macro:
//    UART_CMD_ECHO_EN - enables the ACK/NAK echo outputs on the parser;
//    ACK_BYTE and NAK_BYTE below are only consumed when it is defined.
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

   // One state per byte position of the frame. HUNT waits for the sync
   // byte; the rest name the byte expected next.
   typedef enum logic [2:0] {
      ST_HUNT,
      ST_OP,
      ST_XH,
      ST_XL,
      ST_YH,
      ST_YL,
      ST_CHK
   } parse_state_t;

   // Reply bytes sent back to the host when echo is built in.
   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

   // SYNC, OP, XH, XL, YH, YL, CHK.
   localparam int FRAME_LEN = 7;

   // Plotter opcodes. The parser passes the opcode through untouched;
   // these are here so the motion controller and host tools agree.
   localparam logic [7:0] OP_MOVE     = 8'h01;
   localparam logic [7:0] OP_PEN_UP   = 8'h02;
   localparam logic [7:0] OP_PEN_DOWN = 8'h03;
   localparam logic [7:0] OP_HOME     = 8'h04;

   // XOR of the five payload bytes. The sync byte is deliberately left
   // out so the checksum only protects the command content.
   function automatic logic [7:0] frame_checksum(
      input logic [7:0] op,
      input logic [7:0] xh,
      input logic [7:0] xl,
      input logic [7:0] yh,
      input logic [7:0] yl
   );
      return op ^ xh ^ xl ^ yh ^ yl;
   endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// ---------------------------------------------------------------------------
// uart_cmd_timeout
//
// Purpose:
//    Inter-byte watchdog for the command parser. Counts idle clocks while
//    enabled and flags expiry when the count sits at TIMEOUT_CLKS-1, which
//    means TIMEOUT_CLKS idle clocks have passed since the last clear.
//
// Parameters:
//    TIMEOUT_CLKS - number of idle clocks tolerated between bytes.
//
// Ports:
//    clk    in  1  system clock, rising edge
//    rst_n  in  1  asynchronous active-low reset
//    clear  in  1  restart the count (a byte arrived)
//    enable in  1  count this clock (mid-frame and no byte)
//    expire out 1  combinational: timeout happens at the coming edge
// ---------------------------------------------------------------------------
module uart_cmd_timeout #(
   parameter int TIMEOUT_CLKS = 17360
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int            CW   = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

   logic [CW-1:0] count;

   // Expiry is decoded combinationally so the parser can drop back to HUNT
   // on the very edge the limit is reached. A clear in the same cycle means
   // a byte arrived just in time, so it always beats the timeout.
   assign expire = enable && !clear && (count == LAST);

   // The counter restarts on every byte and after it fires, and otherwise
   // only advances while the parser is waiting mid-frame. It therefore
   // always rests at zero while the parser hunts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || expire) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//
// Purpose:
//    Sits behind the UART receiver. Hunts for the sync byte, assembles the
//    7-byte plotter frame (SYNC OP XH XL YH YL CHK), checks the XOR
//    checksum and hands good commands to the motion controller over a
//    valid/ready handshake. Framing problems are reported as one-cycle
//    error pulses.
//
// Parameters:
//    SYNC_BYTE    - frame start marker
//    TIMEOUT_CLKS - max idle clocks between bytes inside a frame
//
// Ports:
//    i_Clock        in   1  system clock, rising edge
//    i_Reset_n      in   1  asynchronous active-low reset
//    i_RX_DV        in   1  byte strobe from the UART receiver
//    i_RX_Byte      in   8  received byte, valid with i_RX_DV
//    o_Cmd_Valid    out  1  a command is held in the output register
//    i_Cmd_Ready    in   1  consumer takes the command this cycle
//    o_Cmd_Op       out  8  opcode (passed through, not decoded)
//    o_Cmd_X        out 16  X coordinate (big-endian in the frame)
//    o_Cmd_Y        out 16  Y coordinate (big-endian in the frame)
//    o_Chk_Err      out  1  pulse: checksum mismatch
//    o_Timeout_Err  out  1  pulse: inter-byte timeout
//    o_Overrun_Err  out  1  pulse: good frame dropped, output still busy
//    o_Busy         out  1  parser is mid-frame
//    o_Echo_DV      out  1  (UART_CMD_ECHO_EN only) echo byte strobe
//    o_Echo_Byte    out  8  (UART_CMD_ECHO_EN only) ACK or NAK byte
//
// Optional build macro:
//    UART_CMD_ECHO_EN - adds the ACK/NAK echo outputs for a UART
//    transmitter. Without it those ports and their logic do not exist.
// ---------------------------------------------------------------------------
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CLKS = 17360
) (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic        i_RX_DV,
   input  logic [7:0]  i_RX_Byte,
   output logic        o_Cmd_Valid,
   input  logic        i_Cmd_Ready,
   output logic [7:0]  o_Cmd_Op,
   output logic [15:0] o_Cmd_X,
   output logic [15:0] o_Cmd_Y,
   output logic        o_Chk_Err,
   output logic        o_Timeout_Err,
   output logic        o_Overrun_Err,
   output logic        o_Busy
`ifdef UART_CMD_ECHO_EN
   ,
   output logic        o_Echo_DV,
   output logic [7:0]  o_Echo_Byte
`endif
);

   parse_state_t state;

   logic [7:0] op_q;
   logic [7:0] xh_q;
   logic [7:0] xl_q;
   logic [7:0] yh_q;
   logic [7:0] yl_q;

   logic tmo_enable;
   logic tmo_expire;
   logic frame_end;
   logic sum_ok;
   logic out_free;
   logic load_cmd;
   logic drop_cmd;
   logic chk_fail;

   // Frame-end decisions. When the checksum byte arrives we decide whether
   // the frame is bad, can be loaded, or must be dropped because the
   // consumer still has not taken the previous command. A transfer in this
   // same cycle frees the output register, so it counts as free.
   always_comb begin
      tmo_enable = (state != ST_HUNT) && !i_RX_DV;
      frame_end  = i_RX_DV && (state == ST_CHK);
      sum_ok     = (i_RX_Byte == frame_checksum(op_q, xh_q, xl_q, yh_q, yl_q));
      out_free   = !o_Cmd_Valid || i_Cmd_Ready;
      load_cmd   = frame_end && sum_ok && out_free;
      drop_cmd   = frame_end && sum_ok && !out_free;
      chk_fail   = frame_end && !sum_ok;
   end

   // Idle watchdog between bytes of a frame. Any received byte restarts it,
   // and it only counts while a frame is in progress.
   uart_cmd_timeout #(
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) u_timeout (
      .clk    (i_Clock),
      .rst_n  (i_Reset_n),
      .clear  (i_RX_DV),
      .enable (tmo_enable),
      .expire (tmo_expire)
   );

   // Frame parser state machine with all of its registered outputs.
   // Payload bytes land in shadow registers so the output register can
   // keep presenting the previous command untouched until the new frame
   // has passed its checksum. A sync value seen mid-frame is just data;
   // we never resynchronise inside a frame, the timeout covers lost bytes.
   // o_Busy is updated alongside every state change so it always mirrors
   // (state != HUNT) without a cycle of lag. At most one frame-end event
   // can occur per cycle, so the three error pulses are mutually exclusive.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state         <= ST_HUNT;
         op_q          <= '0;
         xh_q          <= '0;
         xl_q          <= '0;
         yh_q          <= '0;
         yl_q          <= '0;
         o_Cmd_Valid   <= 1'b0;
         o_Cmd_Op      <= '0;
         o_Cmd_X       <= '0;
         o_Cmd_Y       <= '0;
         o_Chk_Err     <= 1'b0;
         o_Timeout_Err <= 1'b0;
         o_Overrun_Err <= 1'b0;
         o_Busy        <= 1'b0;
      end else begin
         o_Chk_Err     <= chk_fail;
         o_Overrun_Err <= drop_cmd;
         o_Timeout_Err <= tmo_expire;

         if (load_cmd) begin
            o_Cmd_Valid <= 1'b1;
            o_Cmd_Op    <= op_q;
            o_Cmd_X     <= {xh_q, xl_q};
            o_Cmd_Y     <= {yh_q, yl_q};
         end else if (o_Cmd_Valid && i_Cmd_Ready) begin
            o_Cmd_Valid <= 1'b0;
         end

         if (tmo_expire) begin
            state  <= ST_HUNT;
            o_Busy <= 1'b0;
         end else if (i_RX_DV) begin
            case (state)
               ST_HUNT: begin
                  if (i_RX_Byte == SYNC_BYTE) begin
                     state  <= ST_OP;
                     o_Busy <= 1'b1;
                  end
               end
               ST_OP: begin
                  op_q  <= i_RX_Byte;
                  state <= ST_XH;
               end
               ST_XH: begin
                  xh_q  <= i_RX_Byte;
                  state <= ST_XL;
               end
               ST_XL: begin
                  xl_q  <= i_RX_Byte;
                  state <= ST_YH;
               end
               ST_YH: begin
                  yh_q  <= i_RX_Byte;
                  state <= ST_YL;
               end
               ST_YL: begin
                  yl_q  <= i_RX_Byte;
                  state <= ST_CHK;
               end
               ST_CHK: begin
                  state  <= ST_HUNT;
                  o_Busy <= 1'b0;
               end
               default: begin
                  state  <= ST_HUNT;
                  o_Busy <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef UART_CMD_ECHO_EN
   // Echo back to the host one cycle after every frame ends: ACK when the
   // command was accepted into the output register, NAK for a bad
   // checksum, an overrun drop or a timeout. The byte holds its last
   // value between strobes.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         o_Echo_DV   <= 1'b0;
         o_Echo_Byte <= '0;
      end else begin
         o_Echo_DV <= load_cmd || chk_fail || drop_cmd || tmo_expire;
         if (load_cmd) begin
            o_Echo_Byte <= ACK_BYTE;
         end else if (chk_fail || drop_cmd || tmo_expire) begin
            o_Echo_Byte <= NAK_BYTE;
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Purpose:
//    Self-checking bench for uart_cmd_parser. A table of whole frames is
//    replayed and checked for command/checksum outcome, followed by
//    hand-written sequences for noise, timeout (including the last-clock
//    boundary), overrun, same-cycle transfer-and-load, and reset mid-frame.
//    Expected commands go into a scoreboard queue when a frame is sent and
//    are popped when the DUT hands a command over.
//
// Optional build macro:
//    UART_CMD_ECHO_EN - also connects and checks the echo outputs.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   localparam int TMO = 48;

   logic        clk;
   logic        rst_n;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_op;
   logic [15:0] cmd_x;
   logic [15:0] cmd_y;
   logic        chk_err;
   logic        timeout_err;
   logic        overrun_err;
   logic        busy;
`ifdef UART_CMD_ECHO_EN
   logic        echo_dv;
   logic [7:0]  echo_byte;
`endif

   uart_cmd_parser #(
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .i_Clock       (clk),
      .i_Reset_n     (rst_n),
      .i_RX_DV       (rx_dv),
      .i_RX_Byte     (rx_byte),
      .o_Cmd_Valid   (cmd_valid),
      .i_Cmd_Ready   (cmd_ready),
      .o_Cmd_Op      (cmd_op),
      .o_Cmd_X       (cmd_x),
      .o_Cmd_Y       (cmd_y),
      .o_Chk_Err     (chk_err),
      .o_Timeout_Err (timeout_err),
      .o_Overrun_Err (overrun_err),
      .o_Busy        (busy)
`ifdef UART_CMD_ECHO_EN
      ,
      .o_Echo_DV     (echo_dv),
      .o_Echo_Byte   (echo_byte)
`endif
   );

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [55:0] frame;
      bit          expect_cmd;
      bit          expect_chk;
   } vec_t;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] x;
      logic [15:0] y;
   } cmd_t;

   localparam logic [55:0] GOOD_FRAME  = 56'hA5_01_01F4_00C8_3C;
   localparam logic [55:0] PENUP_FRAME = 56'hA5_02_0000_0000_02;

   vec_t vectors [8];
   cmd_t sb [$];
   cmd_t exp_cmd;

   int checks  = 0;
   int errors  = 0;
   int n_chk   = 0;
   int n_tmo   = 0;
   int n_ovr   = 0;

   // Single comparison point: every check in the bench comes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   // Drive one byte strobe after an optional number of idle clocks.
   task automatic sendByte(input logic [7:0] b, input int gap);
      repeat (gap) @(posedge clk);
      @(posedge clk);
      #1;
      rx_dv   = 1'b1;
      rx_byte = b;
      @(posedge clk);
      #1;
      rx_dv   = 1'b0;
   endtask

   // Send a whole frame back-to-back, recording the expected command first.
   task automatic applyStimulus(input logic [55:0] frame, input bit expect_cmd);
      if (expect_cmd)
         sb.push_back('{op: frame[47:40], x: frame[39:24], y: frame[23:8]});
      for (int i = 0; i < FRAME_LEN; i++)
         sendByte(frame[55-8*i -: 8], 0);
   endtask

   // Monitor: count error pulses, check they never coincide, and score
   // every handshake transfer against the queue.
   always @(negedge clk) begin
      if (chk_err)     n_chk++;
      if (timeout_err) n_tmo++;
      if (overrun_err) n_ovr++;
      if (chk_err || timeout_err || overrun_err)
         checkOutput("pulse_exclusive",
                     32'(chk_err) + 32'(timeout_err) + 32'(overrun_err), 32'd1);
      if (rst_n && cmd_valid && cmd_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_cmd actual op=%h x=%h y=%h required=none",
                     cmd_op, cmd_x, cmd_y);
         end else begin
            exp_cmd = sb.pop_front();
            checkOutput("cmd_op", 32'(cmd_op), 32'(exp_cmd.op));
            checkOutput("cmd_x",  32'(cmd_x),  32'(exp_cmd.x));
            checkOutput("cmd_y",  32'(cmd_y),  32'(exp_cmd.y));
         end
      end
   end

   // Hard stop in case something hangs.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=hung required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c0;
      int t0;
      int o0;
      int seen;

      vectors[0] = '{GOOD_FRAME,               1'b1, 1'b0};
      vectors[1] = '{56'hA5_01_01F4_00C8_3D,   1'b0, 1'b1};
      vectors[2] = '{PENUP_FRAME,              1'b1, 1'b0};
      vectors[3] = '{56'hA5_03_A5A5_1234_25,   1'b1, 1'b0};
      vectors[4] = '{56'hA5_04_FFFF_FFFF_04,   1'b1, 1'b0};
      vectors[5] = '{56'hA5_01_1234_5678_00,   1'b0, 1'b1};
      vectors[6] = '{56'hA5_01_1234_5678_09,   1'b1, 1'b0};
      vectors[7] = '{56'hA5_A5_0000_0000_A5,   1'b1, 1'b0};

      rst_n     = 1'b0;
      rx_dv     = 1'b0;
      rx_byte   = 8'h00;
      cmd_ready = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("reset_valid", 32'(cmd_valid), 0);
      checkOutput("reset_op",    32'(cmd_op),    0);
      checkOutput("reset_x",     32'(cmd_x),     0);
      checkOutput("reset_y",     32'(cmd_y),     0);
      checkOutput("reset_busy",  32'(busy),      0);
      checkOutput("reset_errs",  32'({chk_err, timeout_err, overrun_err}), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Table of whole frames, consumer always ready.
      for (int i = 0; i < 8; i++) begin
         c0 = n_chk;
         t0 = n_tmo;
         o0 = n_ovr;
         applyStimulus(vectors[i].frame, vectors[i].expect_cmd);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_valid_latency", i), 32'(cmd_valid),
                     32'(vectors[i].expect_cmd));
         checkOutput($sformatf("vec%0d_chk_pulse", i), 32'(chk_err),
                     32'(vectors[i].expect_chk));
`ifdef UART_CMD_ECHO_EN
         checkOutput($sformatf("vec%0d_echo_dv", i), 32'(echo_dv), 1);
         checkOutput($sformatf("vec%0d_echo_byte", i), 32'(echo_byte),
                     vectors[i].expect_cmd ? 32'(ACK_BYTE) : 32'(NAK_BYTE));
`endif
         repeat (3) @(negedge clk);
         checkOutput($sformatf("vec%0d_chk_count", i), 32'(n_chk - c0),
                     32'(vectors[i].expect_chk));
         checkOutput($sformatf("vec%0d_tmo_count", i), 32'(n_tmo - t0), 0);
         checkOutput($sformatf("vec%0d_ovr_count", i), 32'(n_ovr - o0), 0);
         checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 0);
         checkOutput($sformatf("vec%0d_sb_drained", i), 32'(sb.size()), 0);
      end

      // Noise before a frame is ignored.
      sendByte(8'h00, 0);
      sendByte(8'hFF, 0);
      sendByte(8'h5A, 0);
      @(negedge clk);
      checkOutput("noise_busy", 32'(busy), 0);
      applyStimulus(GOOD_FRAME, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("noise_sb_drained", 32'(sb.size()), 0);

      // A byte arriving on the very last allowed clock still wins.
      t0 = n_tmo;
      sb.push_back('{op: 8'h01, x: 16'h01F4, y: 16'h00C8});
      sendByte(8'hA5, 0);
      sendByte(8'h01, TMO - 2);
      sendByte(8'h01, 0);
      sendByte(8'hF4, 0);
      sendByte(8'h00, 0);
      sendByte(8'hC8, 0);
      sendByte(8'h3C, 0);
      repeat (4) @(negedge clk);
      checkOutput("tmo_boundary_no_timeout", 32'(n_tmo - t0), 0);
      checkOutput("tmo_boundary_sb_drained", 32'(sb.size()), 0);

      // Stall mid-frame: timeout fires exactly TIMEOUT_CLKS idle clocks on.
      t0 = n_tmo;
      sendByte(8'hA5, 0);
      sendByte(8'h01, 0);
      seen = 0;
      for (int k = 1; k <= TMO + 20; k++) begin
         @(negedge clk);
         if (timeout_err) begin
            seen = k;
            break;
         end
      end
      checkOutput("tmo_pulse_cycle", 32'(seen), 32'(TMO + 1));
      checkOutput("tmo_busy_cleared", 32'(busy), 0);
      repeat (2) @(negedge clk);
      checkOutput("tmo_count", 32'(n_tmo - t0), 1);
      applyStimulus(GOOD_FRAME, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("tmo_recover_sb_drained", 32'(sb.size()), 0);

      // Overrun: consumer stalled, second good frame is dropped.
      cmd_ready = 1'b0;
      applyStimulus(GOOD_FRAME, 1'b1);
      @(negedge clk);
      checkOutput("ovr_first_valid", 32'(cmd_valid), 1);
      o0 = n_ovr;
      applyStimulus(PENUP_FRAME, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("ovr_pulse_count", 32'(n_ovr - o0), 1);
      checkOutput("ovr_hold_valid", 32'(cmd_valid), 1);
      checkOutput("ovr_hold_op", 32'(cmd_op), 32'h01);
      checkOutput("ovr_hold_x",  32'(cmd_x),  32'h01F4);
      checkOutput("ovr_hold_y",  32'(cmd_y),  32'h00C8);
      @(posedge clk);
      #1;
      cmd_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("ovr_valid_dropped", 32'(cmd_valid), 0);
      checkOutput("ovr_sb_drained", 32'(sb.size()), 0);

      // Transfer and new load in the same cycle: no overrun.
      cmd_ready = 1'b0;
      applyStimulus(GOOD_FRAME, 1'b1);
      o0 = n_ovr;
      sb.push_back('{op: 8'h02, x: 16'h0000, y: 16'h0000});
      for (int i = 0; i < FRAME_LEN - 1; i++)
         sendByte(PENUP_FRAME[55-8*i -: 8], 0);
      @(posedge clk);
      #1;
      cmd_ready = 1'b1;
      rx_dv     = 1'b1;
      rx_byte   = 8'h02;
      @(posedge clk);
      #1;
      rx_dv     = 1'b0;
      @(negedge clk);
      checkOutput("same_cycle_valid", 32'(cmd_valid), 1);
      checkOutput("same_cycle_op", 32'(cmd_op), 32'h02);
      repeat (3) @(negedge clk);
      checkOutput("same_cycle_no_overrun", 32'(n_ovr - o0), 0);
      checkOutput("same_cycle_sb_drained", 32'(sb.size()), 0);

      // Reset mid-frame with a command still held.
      cmd_ready = 1'b0;
      applyStimulus(GOOD_FRAME, 1'b0);
      sendByte(8'hA5, 0);
      sendByte(8'h01, 0);
      sendByte(8'h01, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(cmd_valid), 0);
      checkOutput("midrst_op",    32'(cmd_op),    0);
      checkOutput("midrst_x",     32'(cmd_x),     0);
      checkOutput("midrst_y",     32'(cmd_y),     0);
      checkOutput("midrst_busy",  32'(busy),      0);
      @(negedge clk);
      checkOutput("midrst_busy_held", 32'(busy), 0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      cmd_ready = 1'b1;
      applyStimulus(GOOD_FRAME, 1'b1);
      @(negedge clk);
      checkOutput("postrst_valid", 32'(cmd_valid), 1);
`ifdef UART_CMD_ECHO_EN
      checkOutput("postrst_echo_byte", 32'(echo_byte), 32'(ACK_BYTE));
`endif
      repeat (3) @(negedge clk);
      checkOutput("final_sb_empty", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
